// File: rtl/dvi_tx_tmds_encoder.sv
// dvi_tx_tmds_encoder
//   One TMDS 8b/10b encoder lane of the DVI transmitter. Stage 1 applies
//   transition minimisation (XOR/XNOR chain into q_m). Stage 2 selects the
//   DC-balanced 10-bit symbol using a running disparity counter, or inserts
//   a control token during blanking. Latency is two pixel clocks. There is
//   no stall and no handshake.
// Ports:
//   pixel_clock  in   1  pixel clock, rising edge
//   rst          in   1  synchronous active-high reset
//   de           in   1  data enable (1 = active video, 0 = blanking)
//   data         in   8  pixel component, used when de = 1
//   ctrl         in   2  {c1,c0} control bits, used when de = 0
//   tmds         out 10  encoded symbol, bit 0 transmitted first
//   de_out       out  1  de delayed to align with tmds
module dvi_tx_tmds_encoder (
  input  logic       pixel_clock,
  input  logic       rst,
  input  logic       de,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  output logic [9:0] tmds,
  output logic       de_out
);

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  logic [3:0]        n1d_s;
  logic              use_xnor_s;
  logic [8:0]        q_m_s;
  logic [8:0]        q_m_r;
  logic              de_d_r;
  logic [1:0]        ctrl_d_r;

  logic [3:0]        n1_s;
  logic [3:0]        n0_s;
  logic signed [5:0] diff_s;
  logic signed [5:0] cnt_ext_s;
  logic signed [5:0] cnt_sum_s;
  logic              cnt_zero_s;
  logic              cnt_pos_s;
  logic              cnt_neg_s;
  logic [9:0]        tmds_next_s;
  logic signed [4:0] cnt_r;

  // Stage 1 combinational: transition-minimising XOR/XNOR chain
  always_comb begin
    n1d_s      = count_ones(data);
    use_xnor_s = (n1d_s > 4'd4) || ((n1d_s == 4'd4) && (data[0] == 1'b0));
    q_m_s      = 9'd0;
    q_m_s[0]   = data[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor_s) begin
        q_m_s[i] = ~(q_m_s[i-1] ^ data[i]);
      end else begin
        q_m_s[i] = q_m_s[i-1] ^ data[i];
      end
    end
    q_m_s[8] = ~use_xnor_s;
  end

  // Stage 1 register: q_m plus delayed de/ctrl
  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      q_m_r    <= 9'd0;
      de_d_r   <= 1'b0;
      ctrl_d_r <= 2'b00;
    end else begin
      q_m_r    <= q_m_s;
      de_d_r   <= de;
      ctrl_d_r <= ctrl;
    end
  end

  // Stage 2 combinational: DC-balance symbol selection and disparity update
  always_comb begin
    n1_s        = count_ones(q_m_r[7:0]);
    n0_s        = 4'd8 - n1_s;
    // ones minus zeros of q_m[7:0], widened to 6-bit signed
    diff_s      = $signed({2'b00, n1_s}) - $signed({2'b00, n0_s});
    cnt_ext_s   = {cnt_r[4], cnt_r};
    cnt_zero_s  = (cnt_r == 5'sd0);
    cnt_neg_s   = cnt_r[4];
    cnt_pos_s   = !cnt_r[4] && !cnt_zero_s;
    tmds_next_s = 10'h354;
    cnt_sum_s   = 6'sd0;
    if (!de_d_r) begin
      case (ctrl_d_r)
        2'b00:   tmds_next_s = 10'h354;
        2'b01:   tmds_next_s = 10'h0AB;
        2'b10:   tmds_next_s = 10'h154;
        2'b11:   tmds_next_s = 10'h2AB;
        default: tmds_next_s = 10'h354;
      endcase
      cnt_sum_s = 6'sd0;
    end else if (cnt_zero_s || (n1_s == n0_s)) begin
      tmds_next_s = {~q_m_r[8], q_m_r[8], (q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0])};
      if (q_m_r[8]) begin
        cnt_sum_s = cnt_ext_s + diff_s;
      end else begin
        cnt_sum_s = cnt_ext_s - diff_s;
      end
    end else if ((cnt_pos_s && (n1_s > n0_s)) || (cnt_neg_s && (n0_s > n1_s))) begin
      // invert to pull disparity back towards zero
      tmds_next_s = {1'b1, q_m_r[8], ~q_m_r[7:0]};
      if (q_m_r[8]) begin
        cnt_sum_s = cnt_ext_s + 6'sd2 - diff_s;
      end else begin
        cnt_sum_s = cnt_ext_s - diff_s;
      end
    end else begin
      tmds_next_s = {1'b0, q_m_r[8], q_m_r[7:0]};
      if (q_m_r[8]) begin
        cnt_sum_s = cnt_ext_s + diff_s;
      end else begin
        cnt_sum_s = cnt_ext_s - 6'sd2 + diff_s;
      end
    end
  end

  // Stage 2 register: output symbol, aligned de and running disparity
  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      tmds   <= 10'h354;
      de_out <= 1'b0;
      cnt_r  <= 5'sd0;
    end else begin
      tmds   <= tmds_next_s;
      de_out <= de_d_r;
      cnt_r  <= cnt_sum_s[4:0];
    end
  end

endmodule

// File: doc/dvi_tx_tmds_encoder.md
Name: dvi_tx_tmds_encoder

Overview:
- One TMDS 8b/10b encoder lane for the DVI transmitter, running in the `pixel_clock` domain.
- Three instances (blue, green, red) produce the 10-bit symbols that the data-lane serialiser shifts out through the `oddr` and `alt_outbuf_diff` primitives.
- This lane runs in parallel with `dvi_tx_clk_drv`, which forwards `pixel_clock` as the TMDS clock pair.
- It implements DVI 1.0 transition minimisation, DC balance via a running-disparity counter, and control-token insertion during blanking.

Parameters:
- None.

Ports:
- `pixel_clock`  in  1   pixel clock; all logic is on the rising edge.
- `rst`  in  1   synchronous, active-high reset.
- `de`  in  1   data enable; 1 = active video, 0 = blanking.
- `data`  in  8   pixel component, sampled when `de` = 1.
- `ctrl`  in  2   {c1,c0} control bits, sampled when `de` = 0.
- `tmds`  out  10  encoded symbol; bit 0 is transmitted first.
- `de_out`  out  1   `de` delayed to align with `tmds`.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port `pixel_clock`, reset port `rst`.
- Pipeline: two register stages. An input presented at edge N appears on `tmds` and `de_out` after edge N+2. The block accepts a new input every cycle; there is no stall and no handshake.
- Stage 1 (register `q_m[8:0]`, `de_d`, `ctrl_d`):
  - n1d = number of ones in `data`.
  - XNOR path when n1d > 4, or when n1d == 4 and `data[0]` == 0. Otherwise XOR path.
  - `q_m[0]` = `data[0]`.
  - `q_m[i]` = `q_m[i-1]` XNOR (or XOR) `data[i]`, for i = 1..7.
  - `q_m[8]` = 0 for XNOR, 1 for XOR.
- Stage 2 (register `tmds`, `de_out`, cnt):
  - n1 and n0 are the ones and zeros counts of `q_m[7:0]`.
  - cnt is a signed 5-bit running disparity, range -8..+8. All cnt arithmetic is done at 6 bits signed and then truncated.
  - If `de_d` = 0:
    - Output the control token for `ctrl_d`: 00 -> 0x354, 01 -> 0x0AB, 10 -> 0x154, 11 -> 0x2AB.
    - cnt <= 0.
  - Else if cnt == 0 or n1 == n0:
    - `tmds` = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1 - n0) : (n0 - n1).
  - Else if (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1):
    - `tmds` = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + n0 - n1.
  - Else:
    - `tmds` = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*(~q_m[8]) + n1 - n0.
- Reset: on a cycle where `rst` = 1:
  - `q_m` = 0, `de_d` = 0, `ctrl_d` = 0.
  - `tmds` = 0x354, `de_out` = 0, cnt = 0.
- Reset mid-stream: reset applied mid-stream discards both pipeline stages. After `rst` falls, the first valid symbol appears 2 cycles after the first sampled input.
- DE boundaries: no cross-blanking state survives except cnt, which is zeroed by blanking.
  - On a `de` 1->0 edge, the token appears exactly 2 cycles later.
  - On a `de` 0->1 edge, the first data symbol is encoded with cnt = 0.
- `ctrl` is ignored while `de` = 1; `data` is ignored while `de` = 0.
- Invariant: cnt never leaves -8..+8 for any legal input sequence.

Test Plan:
- Reset and blanking: hold `rst` = 1 for 3 cycles -> `tmds` = 0x354, `de_out` = 0. Release with `de` = 0, `ctrl` = 01 -> `tmds` = 0x0AB from edge 2 onward. Repeat with `ctrl` = 10 -> 0x154 and `ctrl` = 11 -> 0x2AB.
- DC balance on zeros: after blanking, drive `de` = 1, `data` = 0x00 continuously -> `tmds` sequence 0x100, 0x3FF, 0x100, …, with cnt stepping 0 -> -8 -> +2 -> -6 …
- XNOR path: after blanking, drive one `data` = 0xFF with `de` = 1 -> `tmds` = 0x200, and cnt = -8 afterwards.
- Latency and DE alignment: after reset and at least 2 cycles of blanking, toggle `de` 0->1->0 with a 5-cycle active window -> `de_out` high for exactly 5 cycles, delayed 2 cycles. The first token after the window shows cnt reset, so the next 0x00 symbol is 0x100.
- Reset mid-stream: drive random data, assert `rst` for 1 cycle -> next cycle `tmds` = 0x354. Resumed data must match a reference model started from cnt = 0.
- Random soak: 100k random `de`/`data`/`ctrl` cycles compared against a golden model -> bit-exact `tmds` match; cnt within ±8; a decoder recovers `data` exactly.
